shared_reg_arbiter: RTL
=======================

Name: shared_reg_arbiter

Overview:
- Shares one DATA_W-bit D-flip-flop register among NUM_REQ requesters.
- Arbitrates write access round-robin, with an optional bounded lock for back-to-back writes.
- Provides registered one-hot grants, a combinational ack and the shared register output with owner tag.
- Sits in front of the flip-flop datapath as its write-port controller.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 8, width of shared register and each write-data lane.
- MAX_HOLD, 4, max consecutive granted cycles per ownership when lock is held (>=1).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; low clears all state immediately.
- req  in  NUM_REQ  per-requester write request.
- lock  in  NUM_REQ  per-requester request to keep grant after a write.
- wdata  in  NUM_REQ*DATA_W  write-data lanes, lane i = wdata[i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  registered one-hot (or zero) ownership.
- ack  out  NUM_REQ  combinational grant & req; write accepted at this edge.
- q  out  DATA_W  shared register value.
- q_owner  out  $clog2(NUM_REQ)  index of last writer.
- q_valid  out  1  high once any write has occurred since reset.

Behaviour:
- Reset (reset==0, async) clears outputs and state:
  - state=IDLE, grant=0, q=0, q_owner=0, q_valid=0, hold_cnt=0.
  - last=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, OWNED. The owner i is the index of the set grant bit.
- Round-robin pick(start): first j with req[j]=1 scanning start, start+1, ... wrapping mod NUM_REQ over all NUM_REQ indices.
- IDLE at posedge:
  - If |req: grant<=onehot(pick(last+1)), hold_cnt<=1, state<=OWNED.
  - Otherwise remain IDLE.
  - No write occurs in IDLE.
- OWNED(i) at posedge, write:
  - If req[i]: q<=wdata lane i, q_owner<=i, q_valid<=1 (ack[i] high during this cycle).
- OWNED(i) at posedge, keep/release:
  - keep = req[i] & lock[i] & (hold_cnt < MAX_HOLD).
  - keep: grant unchanged, hold_cnt<=hold_cnt+1.
  - else: last<=i.
    - If |req: grant<=onehot(pick(i+1)), hold_cnt<=1, stay OWNED. No idle bubble; i may be regranted only if no other requester is pending.
    - Else: grant<=0, state<=IDLE, hold_cnt<=0.
- Latency:
  - req rising in IDLE -> grant next edge -> q updated at the following edge (2 edges).
  - Back-to-back ownership switches in OWNED write every cycle.
- Owner drops req while granted: no write, release that edge.
- lock without req has no effect. lock on a non-owner has no effect.
- Changes to req/wdata/lock of non-owners never alter q.
- At most one grant bit is set; ack is subset of grant.
- MAX_HOLD reached while lock still high: forced release. Lock holder takes lowest priority in the next pick.
- hold_cnt width $clog2(MAX_HOLD+1); it never exceeds MAX_HOLD.
- Reset asserted mid-ownership: grant drops asynchronously, q clears.
  - After release, first grant goes to the lowest-index active requester.

Decomposition:
- shared_reg_arb_pkg holds:
  - typedef enum logic {IDLE, OWNED} arb_state_t.
  - helper function onehot(idx) returning NUM_REQ-bit vector.
- One combinational sub-module rr_pick: inputs req, start; outputs idx, found. Used for both the IDLE and OWNED-release picks.

Test Plan:
- Reset then req=4'b0001, wdata0=8'hA5, lock=0: grant=0001 after edge 1, q=A5, q_owner=0, q_valid=1 after edge 2, then regranted each cycle while sole requester.
- req=4'b1111, no lock, distinct wdata per lane: grant sequence 0001,0010,0100,1000,0001; q follows lanes 0,1,2,3 on consecutive edges.
- req[2]=1, lock[2]=1, others requesting, MAX_HOLD=4: grant=0100 for exactly 4 cycles, 4 writes from lane 2, then grant=1000.
- Owner 1 drops req while req[3]=1: no write that edge, grant moves to 1000 next edge, q holds the old value.
- Reset pulse low mid-ownership (grant=0100, q=3C): grant=0, q=00, q_valid=0 immediately without clock; after release with req=4'b0110, the first grant is 0010.
- All req low while OWNED: grant=0 next edge, state IDLE, q retains its last value.

Source files
------------

// File: rtl/shared_reg_arb_pkg.sv
// Shared types and helpers for the shared register arbiter.
//   arb_state_t : arbiter FSM states
//   onehot()    : index -> one-hot vector (MAX_REQ wide; callers truncate)
package shared_reg_arb_pkg;

  localparam int unsigned MAX_REQ = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // Wide one-hot; the caller casts down to its own requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req scanning from start upward,
// wrapping over all NUM_REQ indices.
//   req   : request vector
//   start : index at which the scan begins
//   idx   : selected index (0 when nothing found)
//   found : any request present
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // Priority scan of a rotated view of req.
  always_comb begin
    int unsigned j;
    j     = 0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(start) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Write-port controller for a single shared DATA_W-bit register.
// Round-robin arbitration among NUM_REQ requesters, with an optional lock
// that keeps ownership for up to MAX_HOLD consecutive cycles.
//   clk     : clock
//   reset   : async active-low reset
//   req     : per-requester write request
//   lock    : per-requester request to keep the grant after a write
//   wdata   : write-data lanes, lane i = wdata[i*DATA_W +: DATA_W]
//   grant   : registered one-hot ownership (or zero)
//   ack     : combinational grant & req (write taken at this edge)
//   q       : shared register value
//   q_owner : index of the last writer
//   q_valid : a write has happened since reset
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 4,
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned MAX_HOLD = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         q,
  output logic [IDX_W-1:0]          q_owner,
  output logic                      q_valid
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic                valid_q, valid_d;

  logic [IDX_W-1:0]    owner_idx;
  logic [DATA_W-1:0]   lane_sel;
  logic [IDX_W-1:0]    pick_start;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic                keep;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(NUM_REQ - 1)) ? '0 : x + IDX_W'(1);
  endfunction

  // Current owner index and its write-data lane.
  always_comb begin
    owner_idx = '0;
    lane_sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner_idx = IDX_W'(i);
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_idx == IDX_W'(i)) lane_sel = wdata[i*DATA_W +: DATA_W];
    end
  end

  // One picker serves both the idle grant and the owned-release handoff.
  assign pick_start = (state_q == IDLE) ? wrap_inc(last_q) : wrap_inc(owner_idx);

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign keep = req[owner_idx] & lock[owner_idx] & (hold_q < HOLD_W'(MAX_HOLD));

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    hold_d  = hold_q;
    q_d     = q_q;
    owner_d = owner_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = NUM_REQ'(onehot(32'(pick_idx)));
          hold_d  = HOLD_W'(1);
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (req[owner_idx]) begin
          q_d     = lane_sel;
          owner_d = owner_idx;
          valid_d = 1'b1;
        end
        if (keep) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          last_d = owner_idx;
          if (pick_found) begin
            grant_d = NUM_REQ'(onehot(32'(pick_idx)));
            hold_d  = HOLD_W'(1);
          end else begin
            grant_d = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State registers; last starts at NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      hold_q  <= '0;
      q_q     <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
    end
  end

  assign grant   = grant_q;
  assign ack     = grant_q & req;
  assign q       = q_q;
  assign q_owner = owner_q;
  assign q_valid = valid_q;

endmodule
